mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/riscv_mem_pkg.sv | 50 +++++
 rtl/mem_arb_select.sv | 54 +++++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package riscv_mem_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  // Transaction life cycle: one memory access is outstanding at most.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Request fields captured at the grant edge and replayed on the memory port.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } mem_txn_t;

  // Instruction fetches are always full-word reads.
  function automatic mem_txn_t fetch_txn(input logic [XLEN-1:0] addr);
    mem_txn_t t;
    t.we    = 1'b0;
    t.addr  = addr;
    t.wdata = '0;
    t.be    = '1;
    return t;
  endfunction

  function automatic mem_txn_t data_txn(input logic            we,
                                        input logic [XLEN-1:0] addr,
                                        input logic [XLEN-1:0] wdata,
                                        input logic [BE_W-1:0] be);
    mem_txn_t t;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.be    = be;
    return t;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Grant selection between fetch and data requesters. Data wins ties until it
// has been granted MAX_DATA_STREAK times in a row; then a waiting fetch wins.
module mem_arb_select
  import riscv_mem_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

  localparam int SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  owner_e        pick;

  // Pick the winner and gate the grants with the arbitration window.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    pick = OWN_D;
    if (if_req && (!d_req || (streak_q == STREAK_MAX))) begin
      pick = OWN_IF;
    end
    if_gnt = arb_en && if_req && (pick == OWN_IF);
    d_gnt  = arb_en && d_req && (pick == OWN_D);
  end

  // Count consecutive data grants, saturating; a fetch grant restarts the count.
  always_comb begin
    streak_d = streak_q;
    if (if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + SW'(1);
    end
  end

  // Streak register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter onto a single
// memory port with at most one transaction outstanding.
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [BE_W-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            proto_err
);

  arb_state_e      state_q, state_d;
  owner_e          owner_q;
  mem_txn_t        txn_q;
  logic            if_rvalid_q, d_rvalid_q;
  logic [XLEN-1:0] if_rdata_q, d_rdata_q;
  logic            proto_err_q;

  logic arb_en;
  logic sel_if_gnt, sel_d_gnt;
  logic resp_accept, resp_spurious;

  // Grants are only offered while idle and never while reset is applied.
  always_comb begin
    arb_en = (state_q == IDLE) && !rst;
  end

  mem_arb_select #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_select (
    .clk    (clk),
    .rst    (rst),
    .arb_en (arb_en),
    .if_req (if_req),
    .d_req  (d_req),
    .if_gnt (sel_if_gnt),
    .d_gnt  (sel_d_gnt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a same-cycle accept+response skips WAIT entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_if_gnt || sel_d_gnt) state_d = ISSUE;
      ISSUE:   if (mem_gnt) state_d = mem_rvalid ? IDLE : WAIT;
      WAIT:    if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and response classification decoded from the current state.
  always_comb begin
    if_gnt        = sel_if_gnt;
    d_gnt         = sel_d_gnt;
    mem_req       = (state_q == ISSUE);
    mem_we        = txn_q.we;
    mem_addr      = txn_q.addr;
    mem_wdata     = txn_q.wdata;
    mem_be        = txn_q.be;
    if_rvalid     = if_rvalid_q;
    if_rdata      = if_rdata_q;
    d_rvalid      = d_rvalid_q;
    d_rdata       = d_rdata_q;
    proto_err     = proto_err_q;
    resp_accept   = mem_rvalid &&
                    (((state_q == ISSUE) && mem_gnt) || (state_q == WAIT));
    resp_spurious = mem_rvalid &&
                    ((state_q == IDLE) || ((state_q == ISSUE) && !mem_gnt));
  end

  // Capture the winner's request so the requester may drop it after the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_q   <= '0;
      owner_q <= OWN_IF;
    end else if (sel_if_gnt) begin
      txn_q   <= fetch_txn(if_addr);
      owner_q <= OWN_IF;
    end else if (sel_d_gnt) begin
      txn_q   <= data_txn(d_we, d_addr, d_wdata, d_be);
      owner_q <= OWN_D;
    end
  end

  // Route an accepted response to its owner as a one-cycle registered pulse;
  // read data holds until that owner's next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= resp_accept && (owner_q == OWN_IF);
      d_rvalid_q  <= resp_accept && (owner_q == OWN_D);
      if (resp_accept && (owner_q == OWN_IF)) begin
        if_rdata_q <= mem_rdata;
      end
      if (resp_accept && (owner_q == OWN_D)) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  // Sticky flag for a memory response that arrives with nothing to answer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err_q <= 1'b0;
    end else if (resp_spurious) begin
      proto_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int MAX_STREAK = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        proto_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int          exp_streak;
  logic [31:0] exp_if_rdata, exp_d_rdata;
  logic        exp_proto;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_DATA_STREAK(MAX_STREAK)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_be       (d_be),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .proto_err  (proto_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_streak   = 0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    exp_proto    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, proto_err} !== 7'b0 ||
        if_rdata !== 32'h0 || d_rdata !== 32'h0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
      failures++;
      $display("FAIL %s reset_values: gnt=%b%b rv=%b%b req=%b we=%b perr=%b ird=%h drd=%h addr=%h wd=%h be=%h, all must be 0",
               tag, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, proto_err,
               if_rdata, d_rdata, mem_addr, mem_wdata, mem_be);
    end
  endtask

  // Asynchronous reset applied mid-cycle; outputs are checked before any clock edge.
  task automatic apply_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    step();
    step();
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle with no requests; optionally a stray memory response.
  task automatic idle_cycle(input string tag, input logic spur);
    if_req     = 1'b0;
    d_req      = 1'b0;
    mem_gnt    = 1'($urandom_range(0, 1));
    mem_rvalid = spur;
    mem_rdata  = $urandom;
    #1;
    checks++;
    if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_quiet: if_gnt=%b d_gnt=%b mem_req=%b, expected 0 0 0",
               tag, if_gnt, d_gnt, mem_req);
    end
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (spur) exp_proto = 1'b1;
    checks++;
    if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || proto_err !== exp_proto ||
        if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
      failures++;
      $display("FAIL %s idle_resp: rv=%b%b perr=%b ird=%h drd=%h, expected rv=00 perr=%b ird=%h drd=%h",
               tag, if_rvalid, d_rvalid, proto_err, if_rdata, d_rdata,
               exp_proto, exp_if_rdata, exp_d_rdata);
    end
  endtask

  // Full transaction: present requests in an IDLE cycle, then act as memory
  // with gdly stall cycles before mem_gnt and rdly cycles between mem_gnt and
  // mem_rvalid (0 = same cycle). spur injects an unaccepted response in ISSUE.
  task automatic do_txn(input string tag, input logic ir, input logic dr,
                        input logic we, input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int gdly, input int rdly, input logic [31:0] rd,
                        input logic spur, output logic got_if);
    logic        exp_f, exp_d;
    logic        e_we;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;

    if_req = ir; if_addr = ia;
    d_req = dr; d_we = we; d_addr = da; d_wdata = wd; d_be = be;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    exp_f = ir && (!dr || exp_streak == MAX_STREAK);
    exp_d = dr && !exp_f;
    got_if = if_gnt;
    checks++;
    if (if_gnt !== exp_f || d_gnt !== exp_d) begin
      failures++;
      $display("FAIL %s grant: if_gnt=%b d_gnt=%b, expected %b %b (streak %0d)",
               tag, if_gnt, d_gnt, exp_f, exp_d, exp_streak);
    end
    if (!exp_f && !exp_d) begin
      step();
      return;
    end

    if (exp_f) begin
      e_we = 1'b0; e_addr = ia; e_wd = 32'h0; e_be = 4'hF;
      exp_streak = 0;
    end else begin
      e_we = we; e_addr = da; e_wd = wd; e_be = be;
      if (exp_streak < MAX_STREAK) exp_streak++;
    end

    step();
    // Requests may now change freely; the latched transaction must not.
    if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
    d_req = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
    d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(0, 15));

    for (int k = 0; k <= gdly; k++) begin
      mem_gnt    = (k == gdly);
      mem_rvalid = ((k == gdly) && (rdly == 0)) || (spur && k == 0 && gdly > 0);
      mem_rdata  = (k == gdly) ? rd : $urandom;
      if (spur && k == 0 && gdly > 0) exp_proto = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== e_we || mem_addr !== e_addr ||
          mem_wdata !== e_wd || mem_be !== e_be || if_gnt !== 1'b0 || d_gnt !== 1'b0 ||
          if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL %s issue[%0d]: req=%b we=%b addr=%h wd=%h be=%h gnt=%b%b rv=%b%b, expected req=1 we=%b addr=%h wd=%h be=%h gnt=00 rv=00",
                 tag, k, mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_gnt, d_gnt,
                 if_rvalid, d_rvalid, e_we, e_addr, e_wd, e_be);
      end
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
    end

    for (int j = 1; j <= rdly; j++) begin
      mem_gnt    = 1'($urandom_range(0, 1));
      mem_rvalid = (j == rdly);
      mem_rdata  = (j == rdly) ? rd : $urandom;
      #1;
      checks++;
      if (mem_req !== 1'b0 || if_gnt !== 1'b0 || d_gnt !== 1'b0 ||
          if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL %s wait[%0d]: req=%b gnt=%b%b rv=%b%b, expected all 0",
                 tag, j, mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid);
      end
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
    end

    if_req = 1'b0; d_req = 1'b0;
    if (exp_f) exp_if_rdata = rd;
    else       exp_d_rdata  = rd;
    checks++;
    if (if_rvalid !== exp_f || d_rvalid !== exp_d || if_rdata !== exp_if_rdata ||
        d_rdata !== exp_d_rdata || proto_err !== exp_proto) begin
      failures++;
      $display("FAIL %s response: rv=%b%b ird=%h drd=%h perr=%b, expected rv=%b%b ird=%h drd=%h perr=%b",
               tag, if_rvalid, d_rvalid, if_rdata, d_rdata, proto_err,
               exp_f, exp_d, exp_if_rdata, exp_d_rdata, exp_proto);
    end
  endtask

  task automatic test_reset();
    logic g;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    model_reset();
    step();
    step();
    check_reset_outputs("reset_held");
    rst = 1'b0;
    idle_cycle("reset_release", 1'b0);
    g = 1'b0;
    check_reset_outputs("after_release");
  endtask

  task automatic test_single_fetch();
    logic g;
    do_txn("single_fetch", 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0,
           0, 1, 32'hDEADBEEF, 1'b0, g);
    idle_cycle("single_fetch_after", 1'b0);
  endtask

  task automatic test_streak_order();
    string order = "";
    logic  g;
    for (int i = 0; i < 6; i++) begin
      do_txn("streak", 1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom,
             $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
             $urandom_range(0, 2), $urandom, 1'b0, g);
      order = {order, g ? "I" : "D"};
    end
    checks++;
    if (order != "DDIDDI") begin
      failures++;
      $display("FAIL streak_order: got %s, expected DDIDDI", order);
    end
  endtask

  task automatic test_store_delayed();
    logic g;
    do_txn("store_delayed", 1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'h12345678, 4'b0011,
           3, 1, 32'hA5A5_0F0F, 1'b0, g);
    idle_cycle("store_after", 1'b0);
  endtask

  task automatic test_random();
    logic g;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle_cycle("rand_idle", 1'b0);
      end else begin
        do_txn("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
               4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 2),
               $urandom, 1'b0, g);
      end
    end
  endtask

  task automatic test_spurious_idle();
    logic g;
    idle_cycle("spur_idle", 1'b1);
    do_txn("spur_idle_txn", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 4'h0,
           1, 0, 32'h0BAD_F00D, 1'b0, g);
    idle_cycle("spur_idle_sticky", 1'b0);
    apply_reset("spur_idle_clear");
    idle_cycle("spur_idle_cleared", 1'b0);
  endtask

  task automatic test_spurious_issue();
    logic g;
    do_txn("spur_issue", 1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 4'hF,
           2, 1, 32'h7777_1111, 1'b1, g);
    apply_reset("spur_issue_clear");
    idle_cycle("spur_issue_cleared", 1'b0);
  endtask

  task automatic test_reset_in_wait();
    logic g;
    // Give the rdata registers non-zero content first.
    do_txn("rw_pre_if", 1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0, 4'h0,
           0, 0, 32'hCAFE_0001, 1'b0, g);
    do_txn("rw_pre_d", 1'b0, 1'b1, 1'b0, 32'h0, 32'h600, 32'h0, 4'hF,
           0, 0, 32'hCAFE_0002, 1'b0, g);
    if_req = 1'b1; if_addr = 32'h700; d_req = 1'b0;
    step();
    mem_gnt = 1'b1; mem_rvalid = 1'b0;
    step();
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || if_gnt !== 1'b0 || mem_addr !== 32'h700) begin
      failures++;
      $display("FAIL reset_in_wait_entry: req=%b if_gnt=%b addr=%h, expected 0 0 00000700",
               mem_req, if_gnt, mem_addr);
    end
    if_req = 1'b1;
    apply_reset("reset_in_wait");
    if_req = 1'b0;
    idle_cycle("late_rvalid", 1'b1);
    do_txn("post_reset_fetch", 1'b1, 1'b0, 1'b0, 32'h800, 32'h0, 32'h0, 4'h0,
           1, 1, 32'h1234_ABCD, 1'b0, g);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_streak_order();
    test_store_delayed();
    test_random();
    test_spurious_idle();
    test_spurious_issue();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
